// File: rtl/stoplight_ctrl.sv
// Two-road intersection controller with parametrised phase timing and a latched pedestrian request.
// Optional pedestrian walk lamps are built when STOPLIGHT_PED_WALK_EN is defined.
module stoplight_ctrl #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 16,
    parameter int unsigned YELLOW_T  = 4,
    parameter int unsigned RED_CLR   = 2,
    parameter int unsigned CROSS_T   = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic Ped,
    output logic SigG,
    output logic SigY,
    output logic SigR,
    output logic XSigG,
    output logic XSigY,
    output logic XSigR,
    output logic ReqPend
`ifdef STOPLIGHT_PED_WALK_EN
    ,
    output logic Walk,
    output logic WalkFlash
`endif
);

    typedef enum logic [2:0] {
        ST_G  = 3'd0,
        ST_Y  = 3'd1,
        ST_R1 = 3'd2,
        ST_X  = 3'd3,
        ST_XY = 3'd4,
        ST_R2 = 3'd5
    } state_t;

    // Timer reload values (duration - 1) per phase.
    localparam logic [CNT_W-1:0] LD_G  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] LD_R  = CNT_W'(RED_CLR - 1);
    localparam logic [CNT_W-1:0] LD_X  = CNT_W'(CROSS_T - 1);

    // Lamp vectors ordered {SigG, SigY, SigR, XSigG, XSigY, XSigR}.
    localparam logic [5:0] LAMP_G  = 6'b100_001;
    localparam logic [5:0] LAMP_Y  = 6'b010_001;
    localparam logic [5:0] LAMP_R  = 6'b001_001;
    localparam logic [5:0] LAMP_X  = 6'b001_100;
    localparam logic [5:0] LAMP_XY = 6'b001_010;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic             req_nxt;
    logic [5:0]       lamps_nxt;
    logic             timer_done;

    assign timer_done = (timer == '0);

    // State register plus timer, request latch and registered lamp outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_G;
            timer   <= LD_G;
            ReqPend <= 1'b0;
            {SigG, SigY, SigR, XSigG, XSigY, XSigR} <= LAMP_G;
        end else begin
            state   <= next_state;
            timer   <= timer_nxt;
            ReqPend <= req_nxt;
            {SigG, SigY, SigR, XSigG, XSigY, XSigR} <= lamps_nxt;
        end
    end

    // Next-state, timer and request-latch logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_G:    if (timer_done && (ReqPend || Ped)) next_state = ST_Y;
            ST_Y:    if (timer_done) next_state = ST_R1;
            ST_R1:   if (timer_done) next_state = ST_X;
            ST_X:    if (timer_done) next_state = ST_XY;
            ST_XY:   if (timer_done) next_state = ST_R2;
            ST_R2:   if (timer_done) next_state = ST_G;
            default: next_state = ST_G;
        endcase

        timer_nxt = timer;
        if (next_state != state) begin
            case (next_state)
                ST_G:         timer_nxt = LD_G;
                ST_Y, ST_XY:  timer_nxt = LD_Y;
                ST_X:         timer_nxt = LD_X;
                default:      timer_nxt = LD_R;
            endcase
        end else if (!timer_done) begin
            timer_nxt = timer - CNT_W'(1);
        end

        // Entering the crossing serves the request and wins over a same-cycle Ped.
        req_nxt = ReqPend;
        if (state == ST_R1 && next_state == ST_X) begin
            req_nxt = 1'b0;
        end else if (Ped && state != ST_X) begin
            req_nxt = 1'b1;
        end
    end

    // Lamp decode of the upcoming state, registered so lamps follow the state register.
    always_comb begin
        lamps_nxt = LAMP_R;
        case (next_state)
            ST_G:    lamps_nxt = LAMP_G;
            ST_Y:    lamps_nxt = LAMP_Y;
            ST_X:    lamps_nxt = LAMP_X;
            ST_XY:   lamps_nxt = LAMP_XY;
            default: lamps_nxt = LAMP_R;
        endcase
    end

`ifdef STOPLIGHT_PED_WALK_EN
    logic walk_nxt;
    logic flash_nxt;

    always_comb begin
        walk_nxt  = (next_state == ST_X);
        flash_nxt = 1'b0;
        if (next_state == ST_XY) begin
            flash_nxt = (state == ST_XY) ? ~WalkFlash : 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            Walk      <= 1'b0;
            WalkFlash <= 1'b0;
        end else begin
            Walk      <= walk_nxt;
            WalkFlash <= flash_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_stoplight_ctrl.sv
// Directed self-checking bench for stoplight_ctrl at default timing parameters.
module tb_stoplight_ctrl;

    localparam int unsigned CNT_W     = 8;
    localparam int unsigned GREEN_MIN = 16;
    localparam int unsigned YELLOW_T  = 4;
    localparam int unsigned RED_CLR   = 2;
    localparam int unsigned CROSS_T   = 12;
    localparam longint unsigned MAX_D = 64'd1 << CNT_W;

    if (GREEN_MIN < 1 || GREEN_MIN > MAX_D || YELLOW_T < 1 || YELLOW_T > MAX_D ||
        RED_CLR < 1 || RED_CLR > MAX_D || CROSS_T < 1 || CROSS_T > MAX_D) begin : g_param_chk
        $error("illegal stoplight duration parameters");
    end

    localparam logic [5:0] L_G  = 6'b100_001;
    localparam logic [5:0] L_Y  = 6'b010_001;
    localparam logic [5:0] L_R  = 6'b001_001;
    localparam logic [5:0] L_X  = 6'b001_100;
    localparam logic [5:0] L_XY = 6'b001_010;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic Ped   = 1'b0;
    logic SigG, SigY, SigR, XSigG, XSigY, XSigR, ReqPend;
    logic [5:0] lamps;
    int checks = 0;
    int errors = 0;

`ifdef STOPLIGHT_PED_WALK_EN
    logic Walk, WalkFlash;
`endif

    stoplight_ctrl #(
        .CNT_W(CNT_W), .GREEN_MIN(GREEN_MIN), .YELLOW_T(YELLOW_T),
        .RED_CLR(RED_CLR), .CROSS_T(CROSS_T)
    ) dut (
        .clock(clock), .reset(reset), .Ped(Ped),
        .SigG(SigG), .SigY(SigY), .SigR(SigR),
        .XSigG(XSigG), .XSigY(XSigY), .XSigR(XSigR),
        .ReqPend(ReqPend)
`ifdef STOPLIGHT_PED_WALK_EN
        , .Walk(Walk), .WalkFlash(WalkFlash)
`endif
    );

    assign lamps = {SigG, SigY, SigR, XSigG, XSigY, XSigR};

    always #5 clock = ~clock;

    // Expected lamps m cycles after a served G phase started (G lasts GREEN_MIN).
    function automatic logic [5:0] exp_lamps(input int m);
        if (m < 16) return L_G;
        if (m < 20) return L_Y;
        if (m < 22) return L_R;
        if (m < 34) return L_X;
        if (m < 38) return L_XY;
        if (m < 40) return L_R;
        return L_G;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Ped   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (lamps !== L_G || ReqPend !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle c=%0d lamps=%b req=%b want lamps=%b req=0", c, lamps, ReqPend, L_G);
            end
`ifdef STOPLIGHT_PED_WALK_EN
            checks++;
            if (Walk !== 1'b0 || WalkFlash !== 1'b0) begin
                errors++;
                $display("FAIL reset_walk c=%0d walk=%b flash=%b want 0 0", c, Walk, WalkFlash);
            end
`endif
            tick();
        end
    endtask

    task automatic test_single_request();
        logic [5:0] el;
        logic       er;
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            Ped = (c == 3);
            el  = exp_lamps(c);
            er  = (c >= 4 && c <= 21);
            checks++;
            if (lamps !== el || ReqPend !== er) begin
                errors++;
                $display("FAIL single_req c=%0d lamps=%b req=%b want lamps=%b req=%b", c, lamps, ReqPend, el, er);
            end
`ifdef STOPLIGHT_PED_WALK_EN
            checks++;
            if (Walk !== (c >= 22 && c <= 33) ||
                WalkFlash !== (c >= 34 && c <= 37 && ((c - 34) % 2 == 0))) begin
                errors++;
                $display("FAIL walk c=%0d walk=%b flash=%b want walk=%b flash=%b", c, Walk, WalkFlash,
                         (c >= 22 && c <= 33), (c >= 34 && c <= 37 && ((c - 34) % 2 == 0)));
            end
`endif
            tick();
        end
        Ped = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] el;
        logic       er;
        int         m;
        do_reset();
        Ped = 1'b1;
        for (int c = 0; c < 120; c++) begin
            m  = c % 40;
            el = exp_lamps(m);
            er = (m >= 35) || (m <= 21 && c != 0);
            checks++;
            if (lamps !== el || ReqPend !== er) begin
                errors++;
                $display("FAIL held_ped c=%0d lamps=%b req=%b want lamps=%b req=%b", c, lamps, ReqPend, el, er);
            end
            tick();
        end
        Ped = 1'b0;
    endtask

    task automatic test_ped_in_x();
        logic [5:0] el;
        logic       er;
        do_reset();
        for (int c = 0; c <= 80; c++) begin
            Ped = (c == 3) || (c == 25);
            el  = exp_lamps(c);
            er  = (c >= 4 && c <= 21);
            checks++;
            if (lamps !== el || ReqPend !== er) begin
                errors++;
                $display("FAIL ped_in_x c=%0d lamps=%b req=%b want lamps=%b req=%b", c, lamps, ReqPend, el, er);
            end
            tick();
        end
        Ped = 1'b0;
    endtask

    task automatic test_ped_in_r2();
        logic [5:0] el;
        logic       er;
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            Ped = (c == 3) || (c == 38);
            el  = (c < 40) ? exp_lamps(c) : exp_lamps(c - 40);
            er  = (c >= 4 && c <= 21) || (c >= 39 && c <= 61);
            checks++;
            if (lamps !== el || ReqPend !== er) begin
                errors++;
                $display("FAIL ped_in_r2 c=%0d lamps=%b req=%b want lamps=%b req=%b", c, lamps, ReqPend, el, er);
            end
            tick();
        end
        Ped = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 35; c++) begin
            Ped = (c == 3);
            tick();
        end
        Ped = 1'b0;
        checks++;
        if (lamps !== L_XY) begin
            errors++;
            $display("FAIL pre_reset_xy lamps=%b want %b", lamps, L_XY);
        end
        reset = 1'b1;
        Ped   = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (lamps !== L_G || ReqPend !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset lamps=%b req=%b want lamps=%b req=0", lamps, ReqPend, L_G);
        end
`ifdef STOPLIGHT_PED_WALK_EN
        checks++;
        if (Walk !== 1'b0 || WalkFlash !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_walk walk=%b flash=%b want 0 0", Walk, WalkFlash);
        end
`endif
        tick();
        Ped = 1'b0;
        checks++;
        if (ReqPend !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_req req=%b want 1", ReqPend);
        end
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (lamps !== L_G) begin
            errors++;
            $display("FAIL reload_g15 lamps=%b want %b", lamps, L_G);
        end
        tick();
        checks++;
        if (lamps !== L_Y) begin
            errors++;
            $display("FAIL reload_y16 lamps=%b want %b", lamps, L_Y);
        end
    endtask

    initial begin
        test_reset();
        test_single_request();
        test_back_to_back();
        test_ped_in_x();
        test_ped_in_r2();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
